// File: rtl/uart_ecc_rx_pkg.sv
// Shared types and helpers for the Hamming-coded UART receiver.
package uart_ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  // Parity bits occupy the power-of-two codeword positions.
  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Codeword position (1-based) of data bit k: the k-th non-power-of-two slot.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < 256; p++) begin
      if (!is_pow2(p) && pos == 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // C parity bits must be able to name every position plus "no error".
  function automatic bit c_ok(input int k, input int c);
    return (2 ** c) >= (k + c + 1);
  endfunction

endpackage

// File: rtl/uart_ecc_rx_if.sv
// Consumer-side bus of the receiver: decoded data, handshake and status.
interface uart_ecc_rx_if #(parameter int K = 4) ();
  logic [K-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         ecc_corr;
  logic         ecc_uncorr;
  logic         frame_err;
  logic         overrun;

  modport master (
    output m_data, m_valid, ecc_corr, ecc_uncorr, frame_err, overrun,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, ecc_corr, ecc_uncorr, frame_err, overrun,
    output m_ready
  );
endinterface

// File: rtl/uart_ecc_rx_hamming_decode.sv
// Combinational Hamming(K+C,K) decoder: syndrome, single-bit fix, data extract.
module hamming_decode
  import uart_ecc_pkg::*;
#(
  parameter int K = 4,
  parameter int C = 3
) (
  input  logic [K+C-1:0] i_code,
  output logic [K-1:0]   o_data,
  output logic           o_corr,
  output logic           o_uncorr
);

  localparam int N = K + C;

  logic [C-1:0] w_syn;
  logic [N-1:0] w_fix;
  logic         w_hit;

  // Syndrome is the XOR of every position index holding a 1; flip the named bit if it exists.
  always_comb begin
    w_syn = '0;
    w_fix = i_code;
    w_hit = 1'b0;
    o_data = '0;
    for (int p = 1; p <= N; p++) begin
      if (i_code[p-1]) w_syn = w_syn ^ C'(p);
    end
    for (int p = 1; p <= N; p++) begin
      if (w_syn == C'(p)) begin
        w_fix[p-1] = ~w_fix[p-1];
        w_hit      = 1'b1;
      end
    end
    // A syndrome beyond N points at no real bit: leave the word raw and flag it.
    o_corr   = w_hit;
    o_uncorr = (w_syn != '0) && !w_hit;
    for (int k = 0; k < K; k++) begin
      o_data[k] = w_fix[data_pos(k) - 1];
    end
  end

endmodule

// File: rtl/uart_ecc_rx.sv
// Oversampling UART receiver for Hamming-coded frames with valid/ready output.
module uart_ecc_rx
  import uart_ecc_pkg::*;
#(
  parameter int K            = 4,
  parameter int C            = 3,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  uart_ecc_rx_if.master rx
);

  localparam int N    = K + C;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = (HALF > 0) ? CW'(HALF - 1) : '0;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  if (!c_ok(K, C)) begin : g_bad_c
    $error("uart_ecc_rx: C too small for K");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_ecc_rx: CLKS_PER_BIT must be >= 1");
  end

  logic          r_sync1, r_sync2;
  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic [N-1:0]  r_code;
  logic [K-1:0]  r_data;
  logic          r_valid, r_corr, r_uncorr, r_ferr, r_ovr;

  logic          w_rxd;
  logic          w_tick;
  logic          w_take;
  logic          w_done;
  logic          w_ferr;
  logic [K-1:0]  w_dec_data;
  logic          w_dec_corr, w_dec_uncorr;

  assign w_rxd  = r_sync2;
  assign w_tick = (r_cnt == '0);

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, shared bit-period counter and bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Next state: the counter counts down to the next sample point; zero means sample now.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_take      = 1'b0;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxd) begin
          w_bit_nxt = '0;
          // With no half-bit delay the detecting sample already is the start-bit check.
          if (HALF == 0) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = CNT_BIT;
          end else begin
            w_state_nxt = START;
            w_cnt_nxt   = CNT_HALF;
          end
        end
      end
      START: begin
        if (w_tick) begin
          if (w_rxd) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_cnt_nxt   = CNT_BIT;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_take    = 1'b1;
          w_cnt_nxt = CNT_BIT;
          if (r_bit == LAST_BIT) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_rxd) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (w_rxd) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Codeword capture: position j+1 lands in r_code[j].
  always_ff @(posedge clk) begin
    if (rst)         r_code        <= '0;
    else if (w_take) r_code[r_bit] <= w_rxd;
  end

  hamming_decode #(.K(K), .C(C)) u_dec (
    .i_code   (r_code),
    .o_data   (w_dec_data),
    .o_corr   (w_dec_corr),
    .o_uncorr (w_dec_uncorr)
  );

  // Output holding register: a new frame replaces the old only if the old is free or leaving now.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_corr   <= 1'b0;
      r_uncorr <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      if (w_done) begin
        if (!r_valid || rx.m_ready) begin
          r_data   <= w_dec_data;
          r_corr   <= w_dec_corr;
          r_uncorr <= w_dec_uncorr;
          r_valid  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx.m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx.m_data     = r_data;
  assign rx.m_valid    = r_valid;
  assign rx.ecc_corr   = r_corr;
  assign rx.ecc_uncorr = r_uncorr;
  assign rx.frame_err  = r_ferr;
  assign rx.overrun    = r_ovr;

endmodule
